// File: rtl/clk_vga_1024_768.sv
//-----------------------------------------------------------------------------
// clk_vga_1024_768
//
// Derives the XGA pixel clock (65 MHz average) from a 100 MHz reference with
// a fractional phase accumulator. Each accumulator overflow produces a
// single-cycle enable (oClkEn). That enable also gates one clk_vga high phase
// onto clk_out1, so clk_out1 is a glitch-free train of 5 ns pulses whose
// average rate is clk_vga * MULT / DIV.
//
// Ports
//   clk_vga   in   reference clock. All state uses the rising edge, except
//                  the enable latch, which uses the falling edge.
//   iReset_n  in   asynchronous active-low reset. Assertion acts at once;
//                  release passes through a 2-flop synchroniser.
//   clk_out1  out  gated pixel clock, equal to clk_vga & enLat.
//   oClkEn    out  single-cycle pixel enable in the clk_vga domain.
//   oLocked   out  high once the generator is running. Sticky until reset.
//
// Parameters
//   MULT, DIV    output/reference frequency ratio; requires 1 <= MULT < DIV.
//   LOCK_CYCLES  synchronised reference edges counted before oLocked rises.
//   ACC_W        accumulator width; requires DIV <= 2^ACC_W - 1.
//
// Configuration macro
//   CLK_VGA_LOCK_DELAY_EN  defined: the lock counter waits LOCK_CYCLES edges.
//                          undefined: no counter is built, and oLocked rises
//                          on the first edge after synchronised release.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module clk_vga_1024_768 #(
  parameter int MULT        = 13,
  parameter int DIV         = 20,
  parameter int LOCK_CYCLES = 16,
  parameter int ACC_W       = 8
) (
  input  logic clk_vga,
  input  logic iReset_n,
  output logic clk_out1,
  output logic oClkEn,
  output logic oLocked
);

  //---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  //---------------------------------------------------------------------------
  if (MULT < 1 || MULT >= DIV || DIV < 2) begin : gRatioCheck
    $error("clk_vga_1024_768: need 1 <= MULT < DIV and DIV >= 2 (MULT=%0d DIV=%0d)",
           MULT, DIV);
  end

  if (ACC_W < 2 || ACC_W > 30) begin : gAccWidthCheck
    $error("clk_vga_1024_768: ACC_W=%0d out of range 2..30", ACC_W);
  end

  if (longint'(DIV) > (longint'(1) << ACC_W) - 1) begin : gAccRangeCheck
    $error("clk_vga_1024_768: DIV=%0d does not fit ACC_W=%0d", DIV, ACC_W);
  end

  if (LOCK_CYCLES < 1) begin : gLockCheck
    $error("clk_vga_1024_768: LOCK_CYCLES must be >= 1 (got %0d)", LOCK_CYCLES);
  end

  //---------------------------------------------------------------------------
  // Reset release synchroniser
  //---------------------------------------------------------------------------
  // NOTE: assertion clears the flops asynchronously. Release only ripples a
  // 1 through both stages, so downstream logic never sees a release that is
  // near the clock edge.
  logic [1:0] rstSync;
  logic       runEn;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) begin
      rstSync <= 2'b00;
    end else begin
      rstSync <= {rstSync[0], 1'b1};
    end
  end

  assign runEn = rstSync[1];

  //---------------------------------------------------------------------------
  // Lock generation
  //---------------------------------------------------------------------------
`ifdef CLK_VGA_LOCK_DELAY_EN
  localparam int                LOCK_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

  logic [LOCK_W-1:0] lockCnt;

  // The counter advances only while unlocked. It stops at LOCK_CYCLES and so
  // never wraps back into a relock.
  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) begin
      lockCnt <= '0;
      oLocked <= 1'b0;
    end else if (runEn && !oLocked) begin
      lockCnt <= lockCnt + LOCK_ONE;
      if (lockCnt == LOCK_LAST) begin
        oLocked <= 1'b1;
      end
    end
  end
`else
  // Without the lock delay, oLocked follows the synchronised release by one
  // edge. Accumulation begins on the edge after that.
  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) begin
      oLocked <= 1'b0;
    end else if (runEn) begin
      oLocked <= 1'b1;
    end
  end
`endif

  //---------------------------------------------------------------------------
  // Fractional phase accumulator
  //---------------------------------------------------------------------------
  // The sum is one bit wider than the accumulator so that acc + MULT cannot
  // overflow before it is compared with DIV.
  localparam logic [ACC_W:0] MULT_X = (ACC_W + 1)'(MULT);
  localparam logic [ACC_W:0] DIV_X  = (ACC_W + 1)'(DIV);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] accNext;
  logic [ACC_W:0]   accSum;
  logic             clkEnNext;

  // NOTE: every variable driven here gets a default before any branch. A
  // path that leaves one unassigned would infer a latch.
  always_comb begin
    accSum    = {1'b0, acc} + MULT_X;
    accNext   = acc;
    clkEnNext = 1'b0;
    if (oLocked) begin
      if (accSum >= DIV_X) begin
        accNext   = ACC_W'(accSum - DIV_X);
        clkEnNext = 1'b1;
      end else begin
        accNext   = ACC_W'(accSum);
      end
    end
  end

  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) begin
      acc    <= '0;
      oClkEn <= 1'b0;
    end else begin
      acc    <= accNext;
      oClkEn <= clkEnNext;
    end
  end

  //---------------------------------------------------------------------------
  // Glitch-free clock gate
  //---------------------------------------------------------------------------
  // enLat changes only on the falling edge, while clk_vga is low, so the AND
  // gate always passes a whole high phase or none of it. Reset clears enLat
  // asynchronously, which truncates a pulse that is already in flight.
  logic enLat;

  always_ff @(negedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) begin
      enLat <= 1'b0;
    end else begin
      enLat <= oClkEn;
    end
  end

  assign clk_out1 = clk_vga & enLat;

  //---------------------------------------------------------------------------
  // Structural invariants
  //---------------------------------------------------------------------------
`ifndef SYNTHESIS
  aEnOnlyWhenLocked: assert property (
    @(posedge clk_vga) disable iff (!iReset_n) oClkEn |-> oLocked);

  aAccInRange: assert property (
    @(posedge clk_vga) disable iff (!iReset_n) ({1'b0, acc} < DIV_X));

  aLockSticky: assert property (
    @(posedge clk_vga) disable iff (!iReset_n) oLocked |=> oLocked);
`endif

endmodule

// File: tb/tb_clk_vga_1024_768.sv
//-----------------------------------------------------------------------------
// tb_clk_vga_1024_768
//
// Directed bench for clk_vga_1024_768. It runs a default instance (13/20) and
// a 1/2 instance, both on a shared 100 MHz clock and reset.
//
// Edge counting: reset is released during a low phase. The first rising edge
// after release is edge 1. The synchroniser output rises on edge 2, so
// oLocked rises on edge 2 + LOCK_CYCLES when the lock delay is built, and on
// edge 3 when it is not.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_clk_vga_1024_768;

`ifdef CLK_VGA_LOCK_DELAY_EN
  localparam int LOCK_EDGE = 2 + 16;
`else
  localparam int LOCK_EDGE = 3;
`endif

  logic clk_vga = 1'b0;
  logic iReset_n;
  logic clk_out1, oClkEn, oLocked;
  logic clkOutHalf, clkEnHalf, lockedHalf;

  int testsRun    = 0;
  int testsFailed = 0;

  // Expected oClkEn for locked cycles 1..20 at 13/20. Bits 2,4,5,7,8,10,11,
  // 13,14,16,17,19 and 20 are set.
  logic [20:1] enPat = 20'b11011011011011011010;

  clk_vga_1024_768 dut (
    .clk_vga (clk_vga),
    .iReset_n(iReset_n),
    .clk_out1(clk_out1),
    .oClkEn  (oClkEn),
    .oLocked (oLocked)
  );

  clk_vga_1024_768 #(.MULT(1), .DIV(2)) dutHalf (
    .clk_vga (clk_vga),
    .iReset_n(iReset_n),
    .clk_out1(clkOutHalf),
    .oClkEn  (clkEnHalf),
    .oLocked (lockedHalf)
  );

  always #5 clk_vga = ~clk_vga;

  // Pulse counting and width measurement on both gated clocks.
  bit  measuring = 1'b0;
  time riseMain, riseHalf;
  int  pulsesMain = 0, badWidthMain = 0;
  int  pulsesHalf = 0, badWidthHalf = 0;

  always @(posedge clk_out1)   riseMain = $time;
  always @(posedge clkOutHalf) riseHalf = $time;

  always @(negedge clk_out1) begin
    if (measuring) begin
      pulsesMain++;
      if ($time - riseMain != 5) badWidthMain++;
    end
  end

  always @(negedge clkOutHalf) begin
    if (measuring) begin
      pulsesHalf++;
      if ($time - riseHalf != 5) badWidthHalf++;
    end
  end

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Releases reset and measures the lock edge. It then checks 40 locked
  // cycles, which is two full periods of the 13/20 pattern.
  task automatic runLockSequence(input string tag);
    int  edges = 0;
    int  idx;
    logic expOut;
    @(negedge clk_vga);
    iReset_n = 1'b1;
    while (!oLocked && edges < 100) begin
      @(posedge clk_vga); #1;
      edges++;
    end
    check($sformatf("%s lock edge", tag), edges, LOCK_EDGE);
    check($sformatf("%s half locked", tag), lockedHalf, 1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_vga); #1;
      idx = ((k - 1) % 20) + 1;
      check($sformatf("%s en c%0d", tag, k), oClkEn, enPat[idx]);
      expOut = (k == 1) ? 1'b0 : enPat[((k - 2) % 20) + 1];
      check($sformatf("%s out hi c%0d", tag, k), clk_out1, expOut);
      check($sformatf("%s half en c%0d", tag, k), clkEnHalf, (k % 2) == 0);
      check($sformatf("%s half out hi c%0d", tag, k), clkOutHalf,
            (k > 1) && ((k % 2) == 1));
      #5;
      check($sformatf("%s out lo c%0d", tag, k), clk_out1, 0);
      check($sformatf("%s half out lo c%0d", tag, k), clkOutHalf, 0);
    end
  endtask

  initial begin
    int enMain = 0, enHalf = 0;
    int lastMain = 0, lastHalf = 0, gapMain = 0, gapHalf = 0;
    int waitCnt = 0;

    // Reset state
    iReset_n = 1'b0;
    repeat (3) @(posedge clk_vga);
    #1;
    check("reset locked", oLocked, 0);
    check("reset en", oClkEn, 0);
    check("reset out", clk_out1, 0);
    check("reset half out", clkOutHalf, 0);

    runLockSequence("init");

    // Long run: 10000 consecutive locked cycles on each instance
    measuring = 1'b1;
    for (int k = 1; k <= 10000; k++) begin
      @(posedge clk_vga); #1;
      if (oClkEn) begin
        enMain++;
        if (lastMain != 0 && k - lastMain > gapMain) gapMain = k - lastMain;
        lastMain = k;
      end
      if (clkEnHalf) begin
        enHalf++;
        if (lastHalf != 0 && k - lastHalf > gapHalf) gapHalf = k - lastHalf;
        lastHalf = k;
      end
    end
    #5;
    measuring = 1'b0;
    check("long en count", enMain, 6500);
    check("long out pulses", pulsesMain, 6500);
    check("long out bad widths", badWidthMain, 0);
    check("long max gap", gapMain, 2);
    check("half en count", enHalf, 5000);
    check("half out pulses", pulsesHalf, 5000);
    check("half out bad widths", badWidthHalf, 0);
    check("half max gap", gapHalf, 2);

    // Reset asserted in the middle of a clk_out1 pulse
    do begin
      @(posedge clk_vga); #1;
      waitCnt++;
    end while (!clk_out1 && waitCnt < 10);
    check("pulse before reset", clk_out1, 1);
    #2 iReset_n = 1'b0;
    #1;
    check("midpulse out", clk_out1, 0);
    check("midpulse en", oClkEn, 0);
    check("midpulse locked", oLocked, 0);
    check("midpulse half locked", lockedHalf, 0);
    repeat (3) @(posedge clk_vga);
    #1;
    check("held reset out", clk_out1, 0);
    check("held reset locked", oLocked, 0);

    runLockSequence("relock");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/clk_vga_1024_768.md
CLK_VGA_1024_768 -- requirements
Module: clk_vga_1024_768

Interface
REQ-001 Parameter MULT, default 13: numerator of output/reference frequency ratio.
REQ-002 Parameter DIV, default 20: denominator of ratio; 100 MHz reference x 13/20 = 65 MHz average, the XGA pixel rate.
REQ-003 Parameter LOCK_CYCLES, default 16: reference cycles from reset release to lock.
REQ-004 Parameter ACC_W, default 8: phase accumulator width; the design SHALL fail elaboration if DIV exceeds 2^ACC_W - 1.
REQ-005 clk_vga  input  1  reference clock, all sequential logic; rising edge except where stated.
REQ-006 iReset_n  input  1  asynchronous, active-low reset.
REQ-007 clk_out1  output  1  generated pixel clock, glitch-free gated pulses of clk_vga high phase.
REQ-008 oClkEn  output  1  single-cycle pixel enable in the clk_vga domain, average rate MULT/DIV.
REQ-009 oLocked  output  1  high once the generator is running; stays high until next reset.

Function
REQ-010 Elaboration SHALL fail unless 1 <= MULT < DIV and DIV >= 2.
REQ-011 Lock counter SHALL count clk_vga rising edges after reset release and set oLocked on the LOCK_CYCLES-th edge.
REQ-012 Lock counter SHALL saturate once oLocked is set; it SHALL never wrap.
REQ-013 While oLocked=0, accumulator SHALL hold 0 and oClkEn SHALL be 0.
REQ-014 On each rising edge with oLocked=1: next = acc + MULT, computed one bit wider than ACC_W.
REQ-015 If next >= DIV, acc <= next - DIV and oClkEn <= 1.
REQ-016 Otherwise acc <= next and oClkEn <= 0.
REQ-017 In any DIV consecutive locked cycles, oClkEn SHALL be high exactly MULT times.
REQ-018 oClkEn SHALL never be high on two cycles separated by more than ceil(DIV/MULT) cycles.
REQ-019 en_lat SHALL capture oClkEn on each falling edge of clk_vga.
REQ-020 clk_out1 SHALL equal clk_vga AND en_lat.
REQ-021 clk_out1 pulse SHALL occur in the clk_vga high phase immediately following each cycle with oClkEn=1.
REQ-022 en_lat SHALL change only while clk_vga is low, so clk_out1 has no glitches or runt pulses.
REQ-023 clk_out1 SHALL stay low while oLocked=0.

Reset
REQ-024 iReset_n low SHALL immediately clear all of the following: lock counter, oLocked, accumulator, oClkEn, en_lat.
REQ-025 clk_out1 SHALL drop low within the same clk_vga phase as reset assertion, including mid-pulse.
REQ-026 After reset release, lock sequence SHALL restart from 0 with the accumulator phase at 0.
REQ-026a Release of reset SHALL be synchronised by a 2-flop synchroniser before it reaches the lock counter.
REQ-026b Assertion of reset SHALL remain asynchronous.

Configuration
REQ-027 Macro CLK_VGA_LOCK_DELAY_EN SHALL control the lock delay.
REQ-027a With CLK_VGA_LOCK_DELAY_EN defined: lock counter and LOCK_CYCLES delay SHALL be present as above.
REQ-027b Without CLK_VGA_LOCK_DELAY_EN: no lock counter SHALL be built.
REQ-027c Without CLK_VGA_LOCK_DELAY_EN: oLocked SHALL go high on the first rising edge after synchronised reset release.
REQ-027d Without CLK_VGA_LOCK_DELAY_EN: accumulation SHALL start on the following edge.

Verification
REQ-028 Defaults, 100 MHz clk_vga, reset released -> oLocked rises on 16th rising edge (macro defined) or 1st edge (macro undefined).
REQ-029 After lock, first 20 locked cycles -> oClkEn high on cycles 2,4,5,7,8,10,11,13,14,16,17,19,20, acc back to 0 after cycle 20.
REQ-030 Run 10000 locked cycles -> exactly 6500 oClkEn pulses and 6500 clk_out1 pulses, each 5 ns wide.
REQ-031 Assert iReset_n while clk_out1 is high -> clk_out1, oClkEn, oLocked all 0 immediately; relock sequence repeats REQ-029 pattern.
REQ-032 MULT=1, DIV=2 -> oClkEn alternates 0,1 from first locked cycle; clk_out1 is a 50 MHz pulse train.
REQ-033 MULT=20, DIV=20 -> elaboration fails.
